dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the array (power of two).
REQ-002 SHALL provide parameter LATENCY, default 2, giving the number of clock edges from request acceptance to response (legal range 1..8).
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_dmem_addr  input  32  byte address from the hart.
REQ-006 i_dmem_ren  input  1  read request.
REQ-007 i_dmem_wen  input  1  write request.
REQ-008 i_dmem_wdata  input  32  write data, little-endian byte lanes.
REQ-009 i_dmem_mask  input  4  byte-lane enables; bit n selects wdata[8n+7:8n].
REQ-010 o_dmem_rdata  output  32  read data; valid only while o_dmem_valid is high, else 0.
REQ-011 o_dmem_busy  output  1  high while a request is outstanding; requests are ignored while high.
REQ-012 o_dmem_valid  output  1  one-cycle response strobe.
REQ-013 o_dmem_fault  output  1  qualifies o_dmem_valid; request was rejected.

Function
REQ-014 SHALL implement states IDLE, WAIT and RESP; o_dmem_busy SHALL be high in WAIT and RESP.
REQ-015 In IDLE with (ren|wen) high at a rising edge, the request SHALL be accepted at that edge (E0).
- On acceptance, the block SHALL latch the fault flag, SHALL load the latency counter with LATENCY-1, and SHALL move to WAIT (or straight to RESP when LATENCY=1).
REQ-016 A non-faulting write SHALL update the array at E0, writing only the lanes whose mask bit is 1 (lane n to byte address addr+n); the other lanes SHALL keep their contents.
REQ-017 A non-faulting read SHALL capture the full word at addr at E0, ignoring the mask, and SHALL present it on o_dmem_rdata during RESP.
REQ-018 WAIT SHALL decrement the counter each edge and SHALL move to RESP when the counter reaches 0.
- o_dmem_valid SHALL be high for exactly the one cycle following edge E0+(LATENCY-1), i.e. the response completes at edge E0+LATENCY.
REQ-019 RESP SHALL return to IDLE at the next edge; a new request SHALL be accepted no earlier than the edge after that (one idle cycle minimum between back-to-back requests).
REQ-020 Write responses SHALL also assert o_dmem_valid, with o_dmem_rdata=0.
REQ-021 Faulting requests SHALL NOT modify the array, SHALL return o_dmem_rdata=0, and SHALL assert o_dmem_fault together with o_dmem_valid at the same latency.
REQ-022 Request inputs SHALL be don't-care outside the acceptance edge, since the block registers all request fields at E0.

Reset
REQ-023 While i_rst_n=0: state=IDLE, counter=0, latched data/fault=0, and o_dmem_busy, o_dmem_valid, o_dmem_fault and o_dmem_rdata SHALL all be 0 (asynchronously).
REQ-024 Array contents SHALL NOT be reset.
REQ-025 Reset during WAIT/RESP SHALL drop the pending response; a write accepted before reset SHALL remain committed.

Configuration
REQ-026 Macro DMEM_RESPONDER_FAULT_EN defined: a request SHALL fault on any of:
- addr[1:0]!=0;
- addr>=4*DEPTH_WORDS;
- ren and wen both high;
- wen with mask=0.
REQ-027 Macro not defined: o_dmem_fault SHALL be constant 0; addr[1:0] SHALL be ignored; the word index SHALL wrap modulo DEPTH_WORDS; ren&wen SHALL behave as a write.

Verification
REQ-028 Write addr=0x10, wdata=0xDEADBEEF, mask=1111; then read 0x10 -> valid exactly 2 cycles after each acceptance edge, rdata=0xDEADBEEF, fault=0.
REQ-029 Pre-fill 0x20=0x11223344; write wdata=0xAABBCCDD, mask=0101; read 0x20 -> 0x11BB33DD.
REQ-030 Request held high continuously -> accepts spaced LATENCY+1 cycles apart; busy=1 for cycles E0..E0+LATENCY; no request accepted while busy.
REQ-031 With FAULT_EN: read addr=0x402 (DEPTH_WORDS=256) -> valid=1, fault=1, rdata=0; array unchanged. Also write with mask=0000 -> valid=1, fault=1, array unchanged.
REQ-032 Assert i_rst_n=0 during WAIT after a write of 0x5 to 0x8 -> outputs 0 immediately, no valid pulse; a later read of 0x8 returns 0x00000005.
REQ-033 LATENCY=1 build: read accepted at edge N -> valid high in the cycle after edge N only.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word memory responder with byte-lane writes.
// Define DMEM_RESPONDER_FAULT_EN to reject misaligned, out-of-range, read+write and empty-mask requests.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_busy,
    output logic        o_dmem_valid,
    output logic        o_dmem_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          fault_q, fault_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   merged;
    logic          accept, fault, wr;
    assign idx    = i_dmem_addr[AW+1:2];
    assign accept = (state_q == IDLE) && (i_dmem_ren || i_dmem_wen);
    assign wr     = i_rst_n && accept && i_dmem_wen && !fault;
`ifdef DMEM_RESPONDER_FAULT_EN
    assign fault = (i_dmem_addr[1:0] != 2'b00) || (i_dmem_addr[31:AW+2] != '0) ||
                   (i_dmem_ren && i_dmem_wen) || (i_dmem_wen && i_dmem_mask == 4'b0000);
`else
    logic unused_addr;
    assign fault       = 1'b0;
    assign unused_addr = ^{i_dmem_addr[31:AW+2], i_dmem_addr[1:0]};
`endif
    always_comb begin
        merged = mem[idx];
        for (int n = 0; n < 4; n++)
            if (i_dmem_mask[n]) merged[8*n +: 8] = i_dmem_wdata[8*n +: 8];
    end
    // The array is deliberately outside the reset domain so committed writes survive reset.
    always_ff @(posedge i_clk)
        if (wr) mem[idx] <= merged;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = (LATENCY == 1) ? RESP : WAIT;
                cnt_d   = 3'(LATENCY - 1);
                fault_d = fault;
                data_d  = (i_dmem_ren && !i_dmem_wen && !fault) ? mem[idx] : 32'h0;
            end
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? RESP : WAIT;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    assign o_dmem_busy  = state_q != IDLE;
    assign o_dmem_valid = state_q == RESP;
    assign o_dmem_rdata = o_dmem_valid ? data_q : 32'h0;
    assign o_dmem_fault = o_dmem_valid && fault_q;
endmodule
